// File: rtl/memory_bus_master_interface.sv
// memory_bus_master_interface
//
// Initiator end of the shared memory bus. It takes one load or store at a time
// from the core over a valid/ready handshake and drives the address, data,
// strobe and byte-mask lines toward the addressed responder. It then waits for
// the responder's fc_bus completion and returns either sign/zero-extended load
// data or a store acknowledge as a single-cycle response. Misaligned requests
// never reach the bus and are answered with an error. A responder that stays
// silent for TIMEOUT_CYCLES access cycles is abandoned with an error.
//
// Ports
//   clk, rst           : clock (rising edge) and asynchronous active-low reset
//   req_valid/ready    : core request handshake
//   req_addr/wr/size   : byte address, store flag, size (0 byte, 1 half, 2 word)
//   req_unsigned       : zero-extend loads when set, sign-extend otherwise
//   req_wdata          : right-justified store data
//   resp_valid         : one-cycle response pulse
//   resp_rdata/err     : extended load data (0 for stores/errors), error flag
//   addr_bus           : transaction byte address
//   data_bus           : bidirectional right-justified data, driven on stores only
//   wr_bus, rd_bus     : write/read strobes
//   data_mask_bus      : right-justified byte mask
//   fc_bus             : responder completion, only a solid 1 counts

module memory_bus_master_interface #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] addr_bus,
  inout  wire  [31:0] data_bus,
  output logic        wr_bus,
  output logic        rd_bus,
  output logic [3:0]  data_mask_bus,
  input  logic        fc_bus
);

  localparam int CntW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic              isWr_q, isWr_d;
  logic [1:0]        size_q, size_d;
  logic              isUnsigned_q, isUnsigned_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CntW-1:0]   timeoutCnt_q, timeoutCnt_d;
  logic [31:0]       respRdata_q, respRdata_d;
  logic              respErr_q, respErr_d;
  logic [31:0]       addrBus_q, addrBus_d;
  logic              wrBus_q, wrBus_d;
  logic              rdBus_q, rdBus_d;
  logic [3:0]        maskBus_q, maskBus_d;
  logic [31:0]       dataOut_q, dataOut_d;
  logic              dataOe_q, dataOe_d;
  logic              inAccess_d;
  logic              fcDone;

  // Half needs addr[0]=0, word needs addr[1:0]=0, size 3 is never legal.
  function automatic logic isMisaligned(input logic [31:0] addr, input logic [1:0] size);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = addr[0];
      2'd2:    bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] sizeMask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      2'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extendLoad(input logic [31:0] raw, input logic [1:0] size,
                                             input logic uns);
    logic [31:0] r;
    case (size)
      2'd0:    r = {{24{~uns & raw[7]}}, raw[7:0]};
      2'd1:    r = {{16{~uns & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  // A floating or unknown completion line must never be read as done.
  assign fcDone = (fc_bus == 1'b1);

  assign req_ready     = (state_q != ACCESS);
  assign resp_valid    = (state_q == RELEASE);
  assign resp_rdata    = respRdata_q;
  assign resp_err      = respErr_q;
  assign addr_bus      = addrBus_q;
  assign wr_bus        = wrBus_q;
  assign rd_bus        = rdBus_q;
  assign data_mask_bus = maskBus_q;
  assign data_bus      = dataOe_q ? dataOut_q : 'z;

  // Next-state logic. Requests are taken whenever the master is not mid-access,
  // so a RELEASE cycle can accept the next request and keep a 3-cycle cadence
  // while still leaving one strobe-low cycle between bus transactions.
  // Bus outputs are computed from the next state so they leave a register.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    isWr_d       = isWr_q;
    size_d       = size_q;
    isUnsigned_d = isUnsigned_q;
    wdata_d      = wdata_q;
    timeoutCnt_d = timeoutCnt_q;
    respRdata_d  = '0;
    respErr_d    = 1'b0;
    inAccess_d   = 1'b0;
    addrBus_d    = '0;
    wrBus_d      = 1'b0;
    rdBus_d      = 1'b0;
    maskBus_d    = '0;
    dataOut_d    = '0;
    dataOe_d     = 1'b0;

    case (state_q)
      ACCESS: begin
        if (fcDone) begin
          state_d = RELEASE;
          if (!isWr_q) begin
            respRdata_d = extendLoad(data_bus, size_q, isUnsigned_q);
          end
        end else if (timeoutCnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = RELEASE;
          respErr_d = 1'b1;
        end else begin
          timeoutCnt_d = timeoutCnt_q + CntW'(1);
        end
      end
      default: begin
        if (req_valid) begin
          addr_d       = req_addr;
          isWr_d       = req_wr;
          size_d       = req_size;
          isUnsigned_d = req_unsigned;
          wdata_d      = req_wdata;
          if (isMisaligned(req_addr, req_size)) begin
            state_d   = RELEASE;
            respErr_d = 1'b1;
          end else begin
            state_d      = ACCESS;
            timeoutCnt_d = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    inAccess_d = (state_d == ACCESS);
    if (inAccess_d) begin
      addrBus_d = addr_d;
      wrBus_d   = isWr_d;
      rdBus_d   = ~isWr_d;
      maskBus_d = sizeMask(size_d);
      dataOut_d = wdata_d & {{8{maskBus_d[3]}}, {8{maskBus_d[2]}},
                             {8{maskBus_d[1]}}, {8{maskBus_d[0]}}};
      dataOe_d  = isWr_d;
    end
  end

  // State and output registers. Reset clears the strobes and releases the data
  // bus at once, so an access in flight is simply abandoned with no response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      isWr_q       <= 1'b0;
      size_q       <= '0;
      isUnsigned_q <= 1'b0;
      wdata_q      <= '0;
      timeoutCnt_q <= '0;
      respRdata_q  <= '0;
      respErr_q    <= 1'b0;
      addrBus_q    <= '0;
      wrBus_q      <= 1'b0;
      rdBus_q      <= 1'b0;
      maskBus_q    <= '0;
      dataOut_q    <= '0;
      dataOe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      isWr_q       <= isWr_d;
      size_q       <= size_d;
      isUnsigned_q <= isUnsigned_d;
      wdata_q      <= wdata_d;
      timeoutCnt_q <= timeoutCnt_d;
      respRdata_q  <= respRdata_d;
      respErr_q    <= respErr_d;
      addrBus_q    <= addrBus_d;
      wrBus_q      <= wrBus_d;
      rdBus_q      <= rdBus_d;
      maskBus_q    <= maskBus_d;
      dataOut_q    <= dataOut_d;
      dataOe_q     <= dataOe_d;
    end
  end

endmodule

// File: tb/tb_memory_bus_master_interface.sv
// Testbench for memory_bus_master_interface.
// A byte-addressed responder answers bus transactions after a programmable
// latency; a separate byte-array reference model predicts every response.

module tb_memory_bus_master_interface;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] addr_bus;
  wire  [31:0] data_bus;
  logic        wr_bus;
  logic        rd_bus;
  logic [3:0]  data_mask_bus;
  wire         fcBus;

  int assertCount = 0;
  int failCount   = 0;
  int bothHigh    = 0;

  // Responder controls and state
  bit          responderOn;
  int          respLatency;
  logic        fcQ;
  int          rspCnt;
  logic        rspDrive;
  logic [31:0] rspData;
  logic        probeEn;
  logic [31:0] probeVal;
  logic [7:0]  busMem [256];
  logic [7:0]  refMem [256];

  memory_bus_master_interface #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wr        (req_wr),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .addr_bus      (addr_bus),
    .data_bus      (data_bus),
    .wr_bus        (wr_bus),
    .rd_bus        (rd_bus),
    .data_mask_bus (data_mask_bus),
    .fc_bus        (fcBus)
  );

  always #5 clk = ~clk;

  assign fcBus    = responderOn ? fcQ : 1'bz;
  assign data_bus = rspDrive ? rspData : (probeEn ? probeVal : 32'bz);

  function automatic logic [31:0] busRead(input logic [31:0] a, input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (m[i]) r[8*i +: 8] = busMem[8'(a[7:0] + 8'(i))];
    return r;
  endfunction

  // Registered responder: waits respLatency cycles after seeing a strobe,
  // then raises fc (and drives load data) until the strobes drop.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcQ      <= 1'b0;
      rspCnt   <= 0;
      rspDrive <= 1'b0;
      rspData  <= '0;
      for (int i = 0; i < 256; i++) busMem[i] <= 8'((i * 37 + 5) % 256);
    end else if (!responderOn || !(wr_bus || rd_bus)) begin
      fcQ      <= 1'b0;
      rspCnt   <= 0;
      rspDrive <= 1'b0;
    end else if (!fcQ) begin
      if (rspCnt >= respLatency) begin
        fcQ <= 1'b1;
        if (wr_bus) begin
          for (int i = 0; i < 4; i++)
            if (data_mask_bus[i]) busMem[8'(addr_bus[7:0] + 8'(i))] <= data_bus[8*i +: 8];
        end else begin
          rspData  <= busRead(addr_bus, data_mask_bus);
          rspDrive <= 1'b1;
        end
      end else begin
        rspCnt <= rspCnt + 1;
      end
    end
  end

  // Strobe exclusivity monitor
  always @(negedge clk)
    if (wr_bus && rd_bus) bothHigh <= bothHigh + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic void initRef();
    for (int i = 0; i < 256; i++) refMem[i] = 8'((i * 37 + 5) % 256);
  endfunction

  function automatic void modelStore(input logic [31:0] a, input int n, input logic [31:0] d);
    longint v = longint'(d);
    for (int i = 0; i < n; i++) begin
      refMem[(int'(a[7:0]) + i) % 256] = 8'(v % 256);
      v = v / 256;
    end
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] a, input int n, input logic u);
    longint v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(refMem[(int'(a[7:0]) + i) % 256]);
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n)) + (longint'(1) << 32);
    return 32'(v);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a value onto data_bus; it reads back intact only if the DUT is not driving.
  task automatic probeReleased(input string tag);
    probeVal = $urandom;
    probeEn  = 1'b1;
    #1;
    checkOutput(tag, data_bus, probeVal);
    probeEn  = 1'b0;
  endtask

  // One complete request: handshake, bus observation, response check.
  task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [1:0] s,
                               input logic u, input logic [31:0] d, input bit noResponder);
    int          cycles, strobeCycles, n, expCycles;
    logic [31:0] seenAddr, seenData, expRdata, expData;
    logic [3:0]  seenMask;
    logic        seenWr, expErr;
    bit          misaligned;

    responderOn = !noResponder;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_wr = w; req_size = s;
    req_unsigned = u; req_wdata = d;
    checkOutput("reqReady", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;

    cycles = 0; strobeCycles = 0;
    seenAddr = '0; seenData = '0; seenMask = '0; seenWr = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_valid) break;
      if (wr_bus || rd_bus) begin
        if (strobeCycles == 0) begin
          seenAddr = addr_bus; seenData = data_bus;
          seenMask = data_mask_bus; seenWr = wr_bus;
        end
        strobeCycles++;
      end
      cycles++;
      if (cycles > 60) break;
    end
    checkOutput("respValid", {31'b0, resp_valid}, 32'd1);

    n = 1 << s;
    misaligned = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
    if (misaligned) begin
      expErr = 1'b1; expRdata = '0; expCycles = 0;
    end else if (noResponder) begin
      expErr = 1'b1; expRdata = '0; expCycles = TIMEOUT;
    end else begin
      expErr = 1'b0; expCycles = 2 + respLatency;
      if (w) begin
        modelStore(a, n, d);
        expRdata = '0;
      end else begin
        expRdata = modelLoad(a, n, u);
      end
    end

    checkOutput("respErr",   {31'b0, resp_err}, {31'b0, expErr});
    checkOutput("respRdata", resp_rdata, expRdata);
    checkOutput("latency",   cycles, expCycles);
    checkOutput("strobeCyc", strobeCycles, expCycles);
    checkOutput("relAddr",   addr_bus, 32'd0);
    checkOutput("relStrobe", {30'b0, wr_bus, rd_bus}, 32'd0);
    checkOutput("relMask",   {28'b0, data_mask_bus}, 32'd0);
    if (strobeCycles > 0) begin
      checkOutput("busAddr", seenAddr, a);
      checkOutput("busMask", {28'b0, seenMask}, 32'((1 << n) - 1));
      checkOutput("busWr",   {31'b0, seenWr}, {31'b0, w});
      if (w) begin
        expData = 32'(longint'(d) % (longint'(1) << (8 * n)));
        checkOutput("busData", seenData, expData);
      end
    end
    @(negedge clk);
    checkOutput("pulseEnd", {31'b0, resp_valid}, 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0]  respBits, strobeBits;
    logic [31:0] firstRd, lastRd, expRd, ra, rd;
    int          nResp, quietResp;
    logic        rw, ru;
    logic [1:0]  rs;
    bit          silent;

    rst = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_wr = 1'b0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0;
    probeEn = 1'b0; probeVal = '0;
    responderOn = 1'b1; respLatency = 0;
    initRef();

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rstReqReady", {31'b0, req_ready}, 32'd1);
    checkOutput("rstRespValid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rstRdata", resp_rdata, 32'd0);
    checkOutput("rstErr", {31'b0, resp_err}, 32'd0);
    checkOutput("rstAddrBus", addr_bus, 32'd0);
    checkOutput("rstStrobes", {30'b0, wr_bus, rd_bus}, 32'd0);
    checkOutput("rstMask", {28'b0, data_mask_bus}, 32'd0);
    probeReleased("rstDataZ");
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] directed: word store, byte loads, misaligned, timeout");
    applyStimulus(32'h0000_0100, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(32'h0000_0103, 1'b1, 2'd0, 1'b0, 32'h1234_5680, 1'b0);
    applyStimulus(32'h0000_0103, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
    checkOutput("byteSigned", resp_rdata, 32'd0);
    applyStimulus(32'h0000_0103, 1'b0, 2'd0, 1'b1, 32'h0, 1'b0);
    applyStimulus(32'h0000_0100, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h0000_0101, 1'b1, 2'd1, 1'b0, 32'hAAAA_5555, 1'b0);
    applyStimulus(32'h0000_0200, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1);
    applyStimulus(32'h0000_0202, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF, 1'b1);

    $display("[TB] directed: back-to-back loads with req_valid held");
    responderOn = 1'b1; respLatency = 0;
    expRd = modelLoad(32'h40, 4, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h40; req_wr = 1'b0; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = '0;
    respBits = '0; strobeBits = '0; nResp = 0; firstRd = '0; lastRd = '0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      respBits[k]   = resp_valid;
      strobeBits[k] = wr_bus | rd_bus;
      if (resp_valid) begin
        if (nResp == 0) firstRd = resp_rdata;
        lastRd = resp_rdata;
        nResp++;
      end
      if (k == 5) req_valid = 1'b0;
    end
    checkOutput("b2bResp", {24'b0, respBits}, 32'h24);
    checkOutput("b2bStrobe", {24'b0, strobeBits}, 32'h1B);
    checkOutput("b2bCount", nResp, 32'd2);
    checkOutput("b2bData0", firstRd, expRd);
    checkOutput("b2bData1", lastRd, expRd);

    $display("[TB] directed: reset during ACCESS");
    responderOn = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h300; req_wr = 1'b1; req_size = 2'd2;
    req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("midWr", {31'b0, wr_bus}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("midRstStrobes", {30'b0, wr_bus, rd_bus}, 32'd0);
    checkOutput("midRstAddr", addr_bus, 32'd0);
    checkOutput("midRstMask", {28'b0, data_mask_bus}, 32'd0);
    probeReleased("midRstDataZ");
    quietResp = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) quietResp++;
    end
    checkOutput("midRstNoResp", quietResp, 32'd0);
    rst = 1'b1;
    initRef();
    @(negedge clk);
    checkOutput("postRstReady", {31'b0, req_ready}, 32'd1);

    $display("[TB] random transactions");
    for (int t = 0; t < 40; t++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      rs = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1));
      rd = $urandom;
      silent = ($urandom_range(0, 7) == 0);
      respLatency = $urandom_range(0, 3);
      applyStimulus(ra, rw, rs, ru, rd, silent);
    end

    checkOutput("strobeExclusive", bothHigh, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
